// File: rtl/edge_frame_sender.sv
// Packs a serial 1-bit edge map into beats and emits one-cycle valid pulses through a holding buffer.
// Optional macro EDGE_COUNT_EN adds edge_count, the number of 1-pixels captured in the current frame.
module edge_frame_sender #(
  parameter int unsigned BEAT_WIDTH      = 240,
  parameter int unsigned FRAME_PIXELS    = 307200,
  parameter int unsigned BEATS_PER_FRAME = FRAME_PIXELS / BEAT_WIDTH,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sof,
  input  logic                  pix_in,
  input  logic                  pix_valid,
  input  logic                  sink_stall,
  output logic [BEAT_WIDTH-1:0] data,
  output logic                  valid,
  output logic [10:0]           beat_count,
  output logic                  frame_done,
  output logic                  overflow
`ifdef EDGE_COUNT_EN
  ,
  output logic [18:0]           edge_count
`endif
);

  localparam int unsigned FILL_W = 8;
  localparam int unsigned PIX_W  = 19;
  localparam int unsigned BCNT_W = 11;
  localparam int unsigned GAP_W  = 4;

  typedef enum logic [1:0] {F_WAIT, F_ACTIVE, F_DRAIN, F_DONE} frame_state_t;
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} send_state_t;

  frame_state_t f_state, f_next;
  send_state_t  s_state, s_next;

  logic [BEAT_WIDTH-1:0] shift_q, hold_q, word_c;
  logic                  hold_full;
  logic [FILL_W-1:0]     fill_cnt, cap_idx_c;
  logic [PIX_W-1:0]      pix_cnt, pix_idx_c;
  logic [GAP_W-1:0]      gap_cnt;
  logic accept_sof_c, capture_c, word_done_c, last_pix_c, gap_last_c;
  logic hold_take_c, load_c, drop_c, drain_ok_c;

  // An accepted sof restarts the frame with this pixel as pixel 0, whatever state we are in.
  always_comb begin : capture_decode
    accept_sof_c = sof & pix_valid & (f_state != F_DONE);
    capture_c    = accept_sof_c | (pix_valid & (f_state == F_ACTIVE));
    cap_idx_c    = accept_sof_c ? '0 : fill_cnt;
    pix_idx_c    = accept_sof_c ? '0 : pix_cnt;
    word_c       = accept_sof_c ? '0 : shift_q;
    word_c[cap_idx_c] = pix_in;
    word_done_c  = capture_c & (cap_idx_c == FILL_W'(BEAT_WIDTH - 1));
    last_pix_c   = capture_c & (pix_idx_c == PIX_W'(FRAME_PIXELS - 1));
    gap_last_c   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    hold_take_c  = (s_state == S_IDLE) & hold_full & ~sink_stall & ~accept_sof_c;
    load_c       = word_done_c & (~hold_full | hold_take_c | accept_sof_c);
    drop_c       = word_done_c & ~load_c;
    drain_ok_c   = ~hold_full & ((s_state == S_IDLE) | ((s_state == S_GAP) & gap_last_c));
  end

  always_comb begin : frame_next
    f_next = f_state;
    if (accept_sof_c) begin
      f_next = last_pix_c ? F_DRAIN : F_ACTIVE;
    end else begin
      case (f_state)
        F_ACTIVE: if (last_pix_c) f_next = F_DRAIN;
        F_DRAIN:  if (drain_ok_c) f_next = F_DONE;
        F_DONE:   f_next = F_WAIT;
        default:  f_next = f_state;
      endcase
    end
  end

  always_comb begin : send_next
    s_next = s_state;
    case (s_state)
      S_IDLE:  if (hold_take_c) s_next = S_PULSE;
      S_PULSE: s_next = S_GAP;
      S_GAP:   if (gap_last_c) s_next = S_IDLE;
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin : state_regs
    if (reset) begin
      f_state <= F_WAIT;
      s_state <= S_IDLE;
    end else begin
      f_state <= f_next;
      s_state <= s_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin : datapath
    if (reset) begin
      shift_q    <= '0;
      hold_q     <= '0;
      hold_full  <= 1'b0;
      fill_cnt   <= '0;
      pix_cnt    <= '0;
      gap_cnt    <= '0;
      data       <= '0;
      valid      <= 1'b0;
      beat_count <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      valid      <= (s_next == S_PULSE);
      frame_done <= (f_next == F_DONE);
      gap_cnt    <= (s_state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (capture_c) begin
        shift_q  <= word_done_c ? '0 : word_c;
        fill_cnt <= word_done_c ? '0 : cap_idx_c + FILL_W'(1);
        pix_cnt  <= pix_idx_c + PIX_W'(1);
      end
      // Loading a completed word wins over emptying, so a word can land the cycle the buffer drains.
      if (load_c) begin
        hold_q    <= word_c;
        hold_full <= 1'b1;
      end else if (accept_sof_c) begin
        hold_q    <= '0;
        hold_full <= 1'b0;
      end else if (hold_take_c) begin
        hold_full <= 1'b0;
      end
      if (hold_take_c) data <= hold_q;
      if (accept_sof_c) begin
        beat_count <= '0;
        overflow   <= drop_c;
      end else begin
        if (hold_take_c && beat_count != BCNT_W'(BEATS_PER_FRAME)) beat_count <= beat_count + BCNT_W'(1);
        if (drop_c) overflow <= 1'b1;
      end
    end
  end

`ifdef EDGE_COUNT_EN
  // Only captures move the count, so it stays frozen between frame end and the next sof.
  always_ff @(posedge clock or posedge reset) begin : edge_counter
    if (reset) begin
      edge_count <= '0;
    end else if (accept_sof_c) begin
      edge_count <= 19'(pix_in);
    end else if (capture_c) begin
      edge_count <= edge_count + 19'(pix_in);
    end
  end
`endif

endmodule

// File: tb/tb_edge_frame_sender.sv
// Randomized bench for edge_frame_sender against a timestamp-based reference model of beats and pulses.
module tb_edge_frame_sender;
  localparam int unsigned BW  = 240;
  localparam int unsigned FP  = 240 * 12;
  localparam int unsigned NB  = FP / BW;
  localparam int unsigned GAP = 2;

  logic clock = 1'b0;
  logic reset, sof, pix_in, pix_valid, sink_stall;
  logic [BW-1:0] data;
  logic valid, frame_done, overflow;
  logic [10:0] beat_count;
`ifdef EDGE_COUNT_EN
  logic [18:0] edge_count;
`endif

  edge_frame_sender #(.BEAT_WIDTH(BW), .FRAME_PIXELS(FP), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset(reset), .sof(sof), .pix_in(pix_in), .pix_valid(pix_valid),
    .sink_stall(sink_stall), .data(data), .valid(valid), .beat_count(beat_count),
    .frame_done(frame_done), .overflow(overflow)
`ifdef EDGE_COUNT_EN
    , .edge_count(edge_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0, cyc = 0;
  int obs_pulses, obs_dones, first_valid, cap239, done_beats;

  // reference model: frame progress as pixel counts, sender availability as a cycle timestamp
  int m_pix, m_next_idle, m_beats, m_edges;
  logic [BW-1:0] m_word, m_hold, exp_data;
  bit m_hold_full, m_ovf, m_active, m_drain, exp_valid, exp_done;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pix = 0; m_word = '0; m_hold = '0; m_hold_full = 0; m_next_idle = 0;
    m_beats = 0; m_ovf = 0; m_active = 0; m_drain = 0; m_edges = 0;
    exp_valid = 0; exp_done = 0; exp_data = '0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit v, input bit st);
    bit acc, take, dexit, nv, nd;
    acc   = s && v && !exp_done;
    take  = m_hold_full && (cyc >= m_next_idle) && !st && !acc;
    dexit = m_drain && !m_hold_full && (cyc + 1 >= m_next_idle) && !acc;
    nv = 0; nd = 0;
    if (take) begin
      nv = 1; exp_data = m_hold; m_hold_full = 0; m_beats++;
      m_next_idle = cyc + GAP + 2;
    end
    if (acc) begin
      m_pix = 0; m_word = '0; m_hold_full = 0; m_beats = 0; m_ovf = 0;
      m_active = 1; m_drain = 0; m_edges = 0;
    end
    if (acc || (v && m_active)) begin
      m_word[m_pix % BW] = p;
      m_pix++;
      m_edges += int'(p);
      if (m_pix % BW == 0) begin
        if (!m_hold_full) begin m_hold = m_word; m_hold_full = 1; end
        else m_ovf = 1;
        m_word = '0;
      end
      if (m_pix == FP) begin m_active = 0; m_drain = 1; end
    end
    if (dexit) begin m_drain = 0; nd = 1; end
    exp_valid = nv; exp_done = nd;
  endtask

  task automatic tick(input bit s, input bit p, input bit v, input bit st);
    sof = s; pix_in = p; pix_valid = v; sink_stall = st;
    model_step(s, p, v, st);
    @(posedge clock); #1;
    cyc++;
    check_eq("valid", 256'(valid), 256'(exp_valid));
    check_eq("frame_done", 256'(frame_done), 256'(exp_done));
    check_eq("overflow", 256'(overflow), 256'(m_ovf));
    check_eq("beat_count", 256'(beat_count), 256'(m_beats));
    check_eq("data", 256'(data), 256'(exp_data));
`ifdef EDGE_COUNT_EN
    check_eq("edge_count", 256'(edge_count), 256'(m_edges));
`endif
    if (valid) begin
      obs_pulses++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (frame_done) begin obs_dones++; done_beats = int'(beat_count); end
  endtask

  // mode: 0 alternating (pixel i = i[0]), 1 random, 2 all ones, 3 all zeros
  // stall_mode: 0 none, 1 random short bursts, 2 held high for frame cycles 200..499
  task automatic send_frame(input int mode, input int vprob, input int stall_mode,
                            input int abort_at, input int want_pulses, input int want_beats);
    int i, t;
    bit v, p, s, st, aborted;
    obs_pulses = 0; obs_dones = 0; first_valid = -1; cap239 = -1; done_beats = -1;
    for (int j = 0; j < 4; j++) begin
      s = bit'($urandom_range(1));
      tick(s, 1'b1, !s, 1'b0);
    end
    i = 0; t = 0; aborted = 0;
    while (i < int'(FP) && t < 20000) begin
      v = (i == 0) || ($urandom_range(99) < vprob);
      case (mode)
        0:       p = bit'(i & 1);
        1:       p = bit'($urandom_range(1));
        2:       p = 1'b1;
        default: p = 1'b0;
      endcase
      s  = v && (i == 0 || (i == abort_at && !aborted));
      st = (stall_mode == 1) ? ($urandom_range(9) == 0) :
           (stall_mode == 2) ? (t >= 200 && t < 500) : 1'b0;
      if (v && i == int'(BW) - 1 && cap239 < 0) cap239 = cyc;
      tick(s, p, v, st);
      if (s) begin
        if (i != 0) aborted = 1;
        i = 1;
      end else if (v) i++;
      t++;
    end
    check_eq("frame_in_time", 256'(t < 20000), 256'(1));
    for (int j = 0; j < 40; j++) tick(1'b0, bit'($urandom_range(1)), bit'($urandom_range(1)), 1'b0);
    check_eq("frame_done_cnt", 256'(obs_dones), 256'(1));
    if (want_pulses >= 0) check_eq("pulse_cnt", 256'(obs_pulses), 256'(want_pulses));
    if (want_beats >= 0) check_eq("beats_at_done", 256'(done_beats), 256'(want_beats));
  endtask

  task automatic reset_mid_pulse();
    int n = 0;
    obs_pulses = 0; obs_dones = 0; first_valid = -1;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    while (!valid && n < 600) begin
      tick(1'b0, bit'($urandom_range(1)), 1'b1, 1'b0);
      n++;
    end
    check_eq("rst_saw_valid", 256'(valid), 256'(1));
    #2 reset = 1'b1;
    #1;
    check_eq("rst_valid", 256'(valid), 256'(0));
    check_eq("rst_data", 256'(data), 256'(0));
    check_eq("rst_beat_count", 256'(beat_count), 256'(0));
    model_reset();
    @(posedge clock); #1 reset = 1'b0;
    obs_pulses = 0;
    for (int j = 0; j < 300; j++) tick(1'b0, bit'($urandom_range(1)), 1'b1, 1'b0);
    check_eq("no_frame_without_sof", 256'(obs_pulses), 256'(0));
  endtask

  initial begin
    reset = 1'b1; sof = 1'b0; pix_in = 1'b0; pix_valid = 1'b0; sink_stall = 1'b0;
    model_reset();
    #2;
    check_eq("reset_valid", 256'(valid), 256'(0));
    check_eq("reset_data", 256'(data), 256'(0));
    check_eq("reset_beat_count", 256'(beat_count), 256'(0));
    check_eq("reset_frame_done", 256'(frame_done), 256'(0));
    check_eq("reset_overflow", 256'(overflow), 256'(0));
    @(posedge clock); #1 reset = 1'b0;

    send_frame(0, 100, 0, -1, NB, NB);
    check_eq("latency", 256'(first_valid - cap239), 256'(2));
    check_eq("alt_overflow", 256'(overflow), 256'(0));
    send_frame(1, 75, 1, -1, -1, -1);
    send_frame(0, 100, 2, -1, NB - 1, NB - 1);
    check_eq("stall_overflow", 256'(overflow), 256'(1));
    send_frame(1, 100, 0, 1000, NB + 4, NB);
    check_eq("abort_overflow", 256'(overflow), 256'(0));
    reset_mid_pulse();
    send_frame(2, 100, 0, -1, NB, NB);
`ifdef EDGE_COUNT_EN
    check_eq("edges_all_ones", 256'(edge_count), 256'(FP));
`endif
    send_frame(3, 90, 0, -1, NB, NB);
`ifdef EDGE_COUNT_EN
    check_eq("edges_all_zeros", 256'(edge_count), 256'(0));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
